// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, the NOP
// bubble word, the PC step and the default reset PC.
package fetch_unit_pkg;

    // At most one memory request is ever outstanding, so two states suffice.
    typedef enum logic {
        FETCH = 1'b0,  // may issue a request
        WAIT  = 1'b1   // request granted, waiting for its response
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Sequential successor of a PC; 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register between instruction memory and IF/ID.
// Flush beats load beats consume; outputs read as a bubble when empty.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ins_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] ins_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] ins_q;

    // Track whether the entry is live and capture each accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too (not only the valid bit) so the
            // outputs are defined zeros straight out of reset.
            pc_q    <= 32'h0;
            ins_q   <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            ins_q   <= ins_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = valid_q ? pc_q  : 32'h0;
    assign ins_o   = valid_q ? ins_q : NOP_INSTR;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/gnt/rvalid handshake
// with instruction memory (one request in flight at most) and feeds IF/ID
// from a one-entry buffer, honouring stalls, branch redirects and CP0
// exception redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        id_shouldStall,
    input  logic        id_shouldJumpOrBranch,
    input  logic [31:0] id_target,
    input  logic        exceptClear,
    input  logic [31:0] except_vector,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q;
    logic         kill_q;

    logic         buf_v;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_ins;

    logic         jump;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         consume;
    logic         fire;
    logic         rsp;
    logic         load;

    // Handshake qualifiers, redirect arbitration and next PC.
    always_comb begin
        // Exception redirect ignores cpu_en; a branch only acts when enabled.
        jump        = id_shouldJumpOrBranch & cpu_en;
        redirect    = exceptClear | jump;
        redirect_pc = exceptClear ? except_vector : id_target;
        consume     = buf_v & cpu_en & ~id_shouldStall;
        // A new request only when the buffer will have room at the edge.
        imem_req    = (state_q == FETCH) & rst & cpu_en & (~buf_v | consume);
        fire        = imem_req & imem_gnt;
        rsp         = (state_q == WAIT) & imem_rvalid;
        // A response is kept only if no redirect has made it stale.
        load        = rsp & ~kill_q & ~redirect;
        // NOTE: default first, so every path assigns pc_d and no latch forms.
        pc_d        = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (fire) begin
            pc_d = next_seq_pc(pc_q);
        end
    end

    // Fetch FSM: PC, address of the request in flight and the kill flag
    // that discards a response belonging to a redirected-away stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            kill_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                FETCH: begin
                    if (fire) begin
                        req_pc_q <= pc_q;
                        state_q  <= WAIT;
                        // Granted in the same cycle as a redirect: the data
                        // coming back is for the old stream.
                        kill_q   <= redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                        kill_q  <= 1'b0;
                    end else if (redirect) begin
                        kill_q  <= 1'b1;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst),
        .flush_i   (redirect),
        .load_i    (load),
        .consume_i (consume),
        .pc_i      (req_pc_q),
        .ins_i     (imem_rdata),
        .valid_o   (buf_v),
        .pc_o      (buf_pc),
        .ins_o     (buf_ins)
    );

    assign imem_addr      = pc_q;
    assign if_valid       = buf_v;
    assign if_instruction = buf_ins;
    assign if_pc_4        = buf_v ? next_seq_pc(buf_pc) : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table covering reset, streaming,
// stall, redirects, cpu_en freeze, PC wrap and mid-transaction reset, then a
// randomized run against a transaction-level model with a random-latency
// instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en = 1'b0;
    logic        id_shouldStall = 1'b0;
    logic        id_shouldJumpOrBranch = 1'b0;
    logic [31:0] id_target = 32'h0;
    logic        exceptClear = 1'b0;
    logic [31:0] except_vector = 32'h0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .cpu_en                (cpu_en),
        .id_shouldStall        (id_shouldStall),
        .id_shouldJumpOrBranch (id_shouldJumpOrBranch),
        .id_target             (id_target),
        .exceptClear           (exceptClear),
        .except_vector         (except_vector),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .if_pc_4               (if_pc_4),
        .if_instruction        (if_instruction),
        .if_valid              (if_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic        rst, en, stall, br;
        logic [31:0] tgt;
        logic        exc;
        logic [31:0] vec;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ins, e_pc4;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic en, input logic stall, input logic br,
        input logic [31:0] tgt, input logic exc, input logic [31:0] vec,
        input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic [31:0] e_ins, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.en = en; v.stall = stall; v.br = br; v.tgt = tgt;
        v.exc = exc; v.vec = vec; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_ins = e_ins; v.e_pc4 = e_pc4;
        return v;
    endfunction

    // Memory contents for the random phase: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8;
        return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    localparam logic [31:0] I1  = 32'h2008_0001, I2 = 32'h2009_0002;
    localparam logic [31:0] I3  = 32'h200A_0003, I4 = 32'h200B_0004;
    localparam logic [31:0] I5  = 32'h200C_0005, I6 = 32'h200D_0006;
    localparam logic [31:0] I7  = 32'h200E_0007, I8 = 32'h200F_0008;
    localparam logic [31:0] I9  = 32'h2010_0009, I10 = 32'h2011_000A;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    // Reference model state (transaction level).
    logic [31:0] m_pc;
    logic        m_out;      // a granted request awaits its response
    logic [31:0] m_addr;     // address of that request
    logic        m_stale;    // its response must be discarded
    logic [31:0] buf_q[$];   // PCs of instructions waiting for ID

    // Random-phase memory state.
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    initial begin
        //             rst en st br tgt           exc vec     gnt rv rdata | req addr         val ins  pc4
        tbl.push_back(mk(0, 0, 0, 0, 0,           0, 0,      0, 0, 0,     0, 0,           0, 0,   0));
        tbl.push_back(mk(0, 1, 0, 0, 0,           0, 0,      1, 0, 0,     0, 0,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 0,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I1,    0, 4,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 4,           1, I1,  4));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I2,    0, 8,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 8,           1, I2,  8));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I3,    0, 12,          0, 0,   0));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      1, 0, 0,     0, 12,          1, I3,  12));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      1, 0, 0,     0, 12,          1, I3,  12));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      1, 0, 0,     0, 12,          1, I3,  12));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 12,          1, I3,  12));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I4,    0, 16,          0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 16,          1, I4,  16));
        tbl.push_back(mk(1, 1, 0, 1, 32'h40,      0, 0,      0, 0, 0,     0, 20,          0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, BAD,   0, 32'h40,      0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h40,      0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I5,    0, 32'h44,      0, 0,   0));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      0, 0, 0,     0, 32'h44,      1, I5,  32'h44));
        tbl.push_back(mk(1, 1, 1, 1, 32'h40,      1, 32'h180, 0, 0, 0,    0, 32'h44,      1, I5,  32'h44));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h180,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I6,    0, 32'h184,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 0, 0,     1, 32'h184,     1, I6,  32'h184));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h184,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 1, 32'h200,     0, 0,      0, 1, BAD,   0, 32'h188,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h200,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I7,    0, 32'h204,     0, 0,   0));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      0, 0, 0,     0, 32'h204,     1, I7,  32'h204));
        tbl.push_back(mk(1, 1, 0, 1, 32'h300,     0, 0,      1, 0, 0,     1, 32'h204,     1, I7,  32'h204));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, BAD,   0, 32'h300,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 0, 0,     1, 32'h300,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h300,     0, 0,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0,           0, 0,      0, 0, 0,     0, 32'h304,     0, 0,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0,           0, 0,      0, 1, I8,    0, 32'h304,     0, 0,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0,           0, 0,      1, 0, 0,     0, 32'h304,     1, I8,  32'h304));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'h304,     1, I8,  32'h304));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I9,    0, 32'h308,     0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0,    0, 0, 0,     1, 32'h308,     1, I9,  32'h308));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 32'hFFFF_FFFC, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 1, I10,   0, 0,           0, 0,   0));
        tbl.push_back(mk(1, 1, 1, 0, 0,           0, 0,      0, 0, 0,     0, 0,           1, I10, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      1, 0, 0,     1, 0,           1, I10, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,           0, 0,      0, 0, 0,     0, 0,           0, 0,   0));
        tbl.push_back(mk(0, 1, 0, 0, 0,           0, 0,      0, 1, BAD,   0, 0,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 0, 0,     1, 0,           0, 0,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0,           1, 32'h80, 0, 0, 0,     0, 0,           0, 0,   0));
        tbl.push_back(mk(1, 1, 0, 0, 0,           0, 0,      0, 0, 0,     1, 32'h80,      0, 0,   0));

        // Directed phase.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst                   = tbl[i].rst;
            cpu_en                = tbl[i].en;
            id_shouldStall        = tbl[i].stall;
            id_shouldJumpOrBranch = tbl[i].br;
            id_target             = tbl[i].tgt;
            exceptClear           = tbl[i].exc;
            except_vector         = tbl[i].vec;
            imem_gnt              = tbl[i].gnt;
            imem_rvalid           = tbl[i].rv;
            imem_rdata            = tbl[i].rdata;
            #1;
            check("vec_req",   i, 32'(imem_req),  32'(tbl[i].e_req));
            check("vec_addr",  i, imem_addr,      tbl[i].e_addr);
            check("vec_valid", i, 32'(if_valid),  32'(tbl[i].e_valid));
            check("vec_ins",   i, if_instruction, tbl[i].e_ins);
            check("vec_pc4",   i, if_pc_4,        tbl[i].e_pc4);
        end

        // Random phase: start from a clean reset of DUT, memory and model.
        @(negedge clk);
        rst = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        mem_pend = 1'b0;
        mem_cnt = 0;
        mem_addr = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic consume, redirect, accept, resp;
            logic [31:0] target;
            logic        exp_req;
            @(negedge clk);
            rst                   = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            cpu_en                = ($urandom_range(0, 9) != 0);
            id_shouldStall        = ($urandom_range(0, 3) == 0);
            id_shouldJumpOrBranch = ($urandom_range(0, 11) == 0);
            id_target             = pick_target();
            exceptClear           = ($urandom_range(0, 39) == 0);
            except_vector         = pick_target();
            imem_gnt              = ($urandom_range(0, 9) < 7);
            // Memory: answer the pending request after its random latency.
            if (!rst) mem_pend = 1'b0;
            imem_rvalid = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) imem_rvalid = 1'b1;
                else mem_cnt--;
            end
            imem_rdata = imem_rvalid ? mem_word(mem_addr) : $urandom;
            if (!rst) begin
                m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_addr = 32'h0;
                buf_q.delete();
            end
            #1;
            consume = (buf_q.size() != 0) && cpu_en && !id_shouldStall;
            exp_req = rst && cpu_en && !m_out && ((buf_q.size() == 0) || consume);
            check("rnd_req",   cyc, 32'(imem_req), 32'(exp_req));
            check("rnd_addr",  cyc, imem_addr, m_pc);
            check("rnd_valid", cyc, 32'(if_valid), 32'(buf_q.size() != 0));
            check("rnd_ins",   cyc, if_instruction,
                  (buf_q.size() != 0) ? mem_word(buf_q[0]) : 32'h0);
            check("rnd_pc4",   cyc, if_pc_4,
                  (buf_q.size() != 0) ? buf_q[0] + 32'd4 : 32'h0);
            // Memory bookkeeping from what the DUT actually did.
            if (imem_rvalid) mem_pend = 1'b0;
            if (rst && imem_req && imem_gnt) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(0, 2);
            end
            // Model advance for the coming edge.
            if (rst) begin
                redirect = exceptClear || (id_shouldJumpOrBranch && cpu_en);
                target   = exceptClear ? except_vector : id_target;
                accept   = exp_req && imem_gnt;
                resp     = m_out && imem_rvalid;
                if (consume) void'(buf_q.pop_front());
                if (resp) begin
                    m_out = 1'b0;
                    if (!m_stale && !redirect) buf_q.push_back(m_addr);
                    m_stale = 1'b0;
                end
                if (accept) begin
                    m_out   = 1'b1;
                    m_addr  = m_pc;
                    m_stale = redirect;
                    m_pc    = m_pc + 32'd4;
                end else if (m_out && redirect) begin
                    m_stale = 1'b1;
                end
                if (redirect) begin
                    m_pc = target;
                    buf_q.delete();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
